spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave_if.sv | 14 +
 rtl/spi_slave.sv | 86 ++++++++
 tb/tb_spi_slave.sv | 118 +++++++++++
 3 files changed

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI pins plus the parallel reply/receive side of spi_slave
interface spi_slave_if;
  logic        sclk;
  logic        cs;
  logic        mosi;
  logic        miso;
  logic [15:0] tx_data;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        busy;
  logic        frame_err;
  modport master (output sclk, cs, mosi, tx_data, input miso, rx_data, rx_valid, busy, frame_err);
  modport slave  (input sclk, cs, mosi, tx_data, output miso, rx_data, rx_valid, busy, frame_err);
endinterface

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 16-bit slave; define SPI_SLAVE_ABORT_DET_EN to pulse frame_err on aborted frames
module spi_slave (
  input logic clk,
  input logic rst,
  spi_slave_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
  state_t      state;
  logic [2:0]  sclk_q, cs_q, mosi_q;
  logic [1:0]  settle;
  logic [4:0]  cnt;
  logic [14:0] tx_sr;
  logic [15:0] rx_sr, rx_data;
  logic        miso, rx_valid, busy;
  logic        sclk_rise, sclk_fall, cs_rise, cs_fall;
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  // settle masks the cs edge produced by the synchronizers flushing their reset value,
  // so a frame already in progress at reset release is not picked up mid-way
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sclk_q   <= 3'b000;
      cs_q     <= 3'b111;
      mosi_q   <= 3'b000;
      settle   <= 2'd3;
      cnt      <= 5'd0;
      tx_sr    <= 15'd0;
      rx_sr    <= 16'd0;
      rx_data  <= 16'd0;
      miso     <= 1'b0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      sclk_q   <= {sclk_q[1:0], bus.sclk};
      cs_q     <= {cs_q[1:0], bus.cs};
      mosi_q   <= {mosi_q[1:0], bus.mosi};
      settle   <= (settle != 2'd0) ? settle - 2'd1 : settle;
      rx_valid <= 1'b0;
      case (state)
        IDLE: if (cs_fall && settle == 2'd0) begin
          tx_sr <= bus.tx_data[14:0];
          miso  <= bus.tx_data[15];
          cnt   <= 5'd0;
          busy  <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: if (cnt == 5'd16) begin
          rx_data  <= rx_sr;
          rx_valid <= 1'b1;
          miso     <= 1'b0;
          state    <= HOLD;
        end else if (cs_rise) begin
          miso  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end else if (sclk_rise) begin
          rx_sr <= {rx_sr[14:0], mosi_q[1]};
          cnt   <= cnt + 5'd1;
        end else if (sclk_fall && cnt != 5'd0) begin
          tx_sr <= {tx_sr[13:0], 1'b0};
          miso  <= tx_sr[14];
        end
        HOLD: if (cs_rise) begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef SPI_SLAVE_ABORT_DET_EN
  logic frame_err;
  always_ff @(posedge clk)
    frame_err <= !rst && state == SHIFT && cnt != 5'd16 && cs_rise;
  assign bus.frame_err = frame_err;
`else
  assign bus.frame_err = 1'b0;
`endif
  assign bus.miso     = miso;
  assign bus.rx_data  = rx_data;
  assign bus.rx_valid = rx_valid;
  assign bus.busy     = busy;
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed-frame bench for spi_slave acting as the SPI master
module tb_spi_slave;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #4 clk = ~clk;
  spi_slave_if bus();
  spi_slave dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0, errors = 0, nv = 0, ne = 0;
  int v0, e0, err_exp;
  logic [31:0] mi;
  logic bm;
  always @(negedge clk) begin
    if (bus.rx_valid) nv++;
    if (bus.frame_err) ne++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic xfer(input logic [15:0] mo, input int nbits, input int half, input int rst_bit,
                      input int chg_bit, input logic [15:0] chg_val, output logic [31:0] got, output logic busy_mid);
    logic [15:0] sh;
    got = 32'd0;
    busy_mid = 1'b0;
    bus.cs = 1'b0;
    bus.mosi = mo[15];
    wait_clk(half);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_bit) begin
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
      end
      if (i == chg_bit) bus.tx_data = chg_val;
      got = {got[30:0], bus.miso};
      if (i == 0) busy_mid = bus.busy;
      bus.sclk = 1'b1;
      wait_clk(half);
      bus.sclk = 1'b0;
      sh = mo << (i + 1);
      bus.mosi = sh[15];
      wait_clk(half);
    end
    bus.cs = 1'b1;
    wait_clk(4 * half);
  endtask
  initial begin
`ifdef SPI_SLAVE_ABORT_DET_EN
    err_exp = 1;
`else
    err_exp = 0;
`endif
    bus.sclk = 1'b0;
    bus.cs = 1'b1;
    bus.mosi = 1'b0;
    bus.tx_data = 16'hA55A;
    wait_clk(4);
    check("rst_rx_data", {16'd0, bus.rx_data}, 32'd0);
    check("rst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_miso", {31'd0, bus.miso}, 32'd0);
    check("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
    rst = 1'b0;
    wait_clk(6);
    v0 = nv;
    xfer(16'h1234, 16, 250, -1, -1, 16'h0, mi, bm);
    check("f1_miso_word", {16'd0, mi[15:0]}, 32'h0000A55A);
    check("f1_rx_data", {16'd0, bus.rx_data}, 32'h00001234);
    check("f1_rx_valid_cnt", nv - v0, 32'd1);
    check("f1_busy_mid", {31'd0, bm}, 32'd1);
    check("f1_busy_end", {31'd0, bus.busy}, 32'd0);
    bus.tx_data = 16'h0000;
    v0 = nv;
    xfer(16'hFFFF, 16, 20, -1, -1, 16'h0, mi, bm);
    check("b2b_rx_first", {16'd0, bus.rx_data}, 32'h0000FFFF);
    check("b2b_miso_first", {16'd0, mi[15:0]}, 32'h00000000);
    xfer(16'h0001, 16, 20, -1, -1, 16'h0, mi, bm);
    check("b2b_rx_second", {16'd0, bus.rx_data}, 32'h00000001);
    check("b2b_rx_valid_cnt", nv - v0, 32'd2);
    v0 = nv;
    e0 = ne;
    xfer(16'hBEEF, 7, 20, -1, -1, 16'h0, mi, bm);
    check("abort_rx_data", {16'd0, bus.rx_data}, 32'h00000001);
    check("abort_rx_valid_cnt", nv - v0, 32'd0);
    check("abort_frame_err_cnt", ne - e0, err_exp);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    bus.tx_data = 16'hFFFF;
    v0 = nv;
    xfer(16'hC3C3, 20, 20, -1, -1, 16'h0, mi, bm);
    check("ovr_rx_data", {16'd0, bus.rx_data}, 32'h0000C3C3);
    check("ovr_miso_bits", {12'd0, mi[19:0]}, 32'h000FFFF0);
    check("ovr_rx_valid_cnt", nv - v0, 32'd1);
    bus.tx_data = 16'h1111;
    v0 = nv;
    e0 = ne;
    xfer(16'h1111, 16, 20, 8, -1, 16'h0, mi, bm);
    check("rstmid_rx_valid_cnt", nv - v0, 32'd0);
    check("rstmid_frame_err_cnt", ne - e0, 32'd0);
    check("rstmid_rx_data", {16'd0, bus.rx_data}, 32'd0);
    check("rstmid_busy", {31'd0, bus.busy}, 32'd0);
    v0 = nv;
    xfer(16'h5A5A, 16, 20, -1, -1, 16'h0, mi, bm);
    check("post_rst_rx_data", {16'd0, bus.rx_data}, 32'h00005A5A);
    check("post_rst_rx_valid_cnt", nv - v0, 32'd1);
    bus.tx_data = 16'hF0F0;
    xfer(16'h0000, 16, 20, -1, 5, 16'h0F0F, mi, bm);
    check("txchg_miso_word", {16'd0, mi[15:0]}, 32'h0000F0F0);
    check("txchg_rx_data", {16'd0, bus.rx_data}, 32'h00000000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
